// File: rtl/control_sequencer.sv
// Hardwired Moore control unit sequencing the bus datapath through fetch/decode/execute.
// Define CU_MULDIV_EN to decode mul/div (LO/HI writeback); otherwise both act as nop.
module control_sequencer #(
    parameter int         MEM_WAIT = 1,
    parameter logic [3:0] ALU_ADD  = 4'd3,
    parameter logic [3:0] ALU_SUB  = 4'd4,
    parameter logic [3:0] ALU_AND  = 4'd5,
    parameter logic [3:0] ALU_OR   = 4'd6,
    parameter logic [3:0] ALU_MUL  = 4'd15,
    parameter logic [3:0] ALU_DIV  = 4'd14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IRval,
    output logic        PCout, Zlowout, Zhighout, MDRout, Cout, Rout, BAout,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin, HIin, LOin,
    output logic        GRA, GRB, GRC,
    output logic        IncPc,
    output logic        read, write,
    output logic [1:0]  mdr_read,
    output logic [3:0]  control,
    output logic        run,
    output logic [4:0]  state_D
);
    typedef enum logic [4:0] {
        S_IDLE = 5'd0, S_T0 = 5'd1, S_T1 = 5'd2, S_T2 = 5'd3, S_T3 = 5'd4,
        S_T4 = 5'd5, S_T5 = 5'd6, S_T6 = 5'd7, S_T7 = 5'd8, S_HALT = 5'd31
    } state_t;

    typedef struct packed {
        logic pcout, zlowout, zhighout, mdrout, cout, rout, baout;
        logic pcin, irin, marin, mdrin, yin, zin, rin, hiin, loin;
        logic gra, grb, grc, incpc, rd, wr;
        logic [1:0] mdr_sel;
        logic [3:0] alu;
        logic run;
    } ctrl_t;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    state_t     r_state, w_next_state;
    logic [2:0] r_cnt, w_next_cnt;
    ctrl_t      r_ctrl, w_ctrl;

    logic [4:0] w_opcode;
    logic       w_is_alu3, w_is_imm, w_is_ldi, w_is_ld, w_is_st, w_is_jr, w_is_halt;
    logic       w_is_muldiv, w_is_addr;
    logic [3:0] w_alu_op;
    logic       w_unused_ir;

    assign w_opcode    = IRval[31:27];
    assign w_unused_ir = ^IRval[26:0];

    always_comb begin
        w_is_alu3 = w_opcode inside {5'd3, 5'd4, 5'd5, 5'd6};
        w_is_imm  = w_opcode inside {5'd12, 5'd13, 5'd14};
        w_is_ldi  = (w_opcode == 5'd1);
        w_is_ld   = (w_opcode == 5'd0);
        w_is_st   = (w_opcode == 5'd2);
        w_is_jr   = (w_opcode == 5'd20);
        w_is_halt = (w_opcode == 5'd25);
`ifdef CU_MULDIV_EN
        w_is_muldiv = (w_opcode == 5'd15) || (w_opcode == 5'd16);
`else
        w_is_muldiv = 1'b0;
`endif
        w_is_addr = w_is_ldi | w_is_ld | w_is_st;
        case (w_opcode)
            5'd4:         w_alu_op = ALU_SUB;
            5'd5, 5'd13:  w_alu_op = ALU_AND;
            5'd6, 5'd14:  w_alu_op = ALU_OR;
            5'd15:        w_alu_op = ALU_MUL;
            5'd16:        w_alu_op = ALU_DIV;
            default:      w_alu_op = ALU_ADD;
        endcase
    end

    // Memory waits: the counter is loaded on entry and the state holds until it reaches 0.
    always_comb begin
        w_next_state = S_IDLE;
        w_next_cnt   = 3'd0;
        case (r_state)
            S_IDLE: w_next_state = S_T0;
            S_T0: begin
                w_next_state = S_T1;
                w_next_cnt   = WAIT_LOAD;
            end
            S_T1: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = S_T2;
                end else begin
                    w_next_state = S_T1;
                    w_next_cnt   = r_cnt - 3'd1;
                end
            end
            S_T2: w_next_state = S_T3;
            S_T3: begin
                if (w_is_halt)
                    w_next_state = S_HALT;
                else if (w_is_alu3 || w_is_imm || w_is_addr || w_is_muldiv)
                    w_next_state = S_T4;
                else
                    w_next_state = S_T0;
            end
            S_T4: w_next_state = S_T5;
            S_T5: begin
                if (w_is_ld) begin
                    w_next_state = S_T6;
                    w_next_cnt   = WAIT_LOAD;
                end else if (w_is_st || w_is_muldiv) begin
                    w_next_state = S_T6;
                end else begin
                    w_next_state = S_T0;
                end
            end
            S_T6: begin
                if (w_is_ld && r_cnt != 3'd0) begin
                    w_next_state = S_T6;
                    w_next_cnt   = r_cnt - 3'd1;
                end else if (w_is_ld) begin
                    w_next_state = S_T7;
                end else if (w_is_st) begin
                    w_next_state = S_T7;
                    w_next_cnt   = WAIT_LOAD;
                end else begin
                    w_next_state = S_T0;
                end
            end
            S_T7: begin
                if (w_is_st && r_cnt != 3'd0) begin
                    w_next_state = S_T7;
                    w_next_cnt   = r_cnt - 3'd1;
                end else begin
                    w_next_state = S_T0;
                end
            end
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered so they register in step with it.
    always_comb begin
        w_ctrl     = '0;
        w_ctrl.run = (w_next_state != S_IDLE) && (w_next_state != S_HALT);
        case (w_next_state)
            S_T0: begin
                w_ctrl.pcout = 1'b1; w_ctrl.marin = 1'b1; w_ctrl.incpc = 1'b1;
                w_ctrl.zin   = 1'b1; w_ctrl.alu   = ALU_ADD;
            end
            S_T1: begin
                w_ctrl.zlowout = 1'b1; w_ctrl.pcin = 1'b1; w_ctrl.rd = 1'b1;
                w_ctrl.mdr_sel = 2'b01; w_ctrl.mdrin = (w_next_cnt == 3'd0);
            end
            S_T2: begin
                w_ctrl.mdrout = 1'b1; w_ctrl.irin = 1'b1;
            end
            S_T3: begin
                if (w_is_alu3 || w_is_imm) begin
                    w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.yin = 1'b1;
                end else if (w_is_addr) begin
                    w_ctrl.grb = 1'b1; w_ctrl.baout = 1'b1; w_ctrl.yin = 1'b1;
                end else if (w_is_jr) begin
                    w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pcin = 1'b1;
                end else if (w_is_muldiv) begin
                    w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.yin = 1'b1;
                end
            end
            S_T4: begin
                w_ctrl.zin = 1'b1;
                w_ctrl.alu = w_alu_op;
                if (w_is_alu3) begin
                    w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1;
                end else if (w_is_muldiv) begin
                    w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1;
                end else begin
                    w_ctrl.cout = 1'b1;
                    if (w_is_addr) w_ctrl.alu = ALU_ADD;
                end
            end
            S_T5: begin
                w_ctrl.zlowout = 1'b1;
                if (w_is_ld || w_is_st) begin
                    w_ctrl.marin = 1'b1;
                end else if (w_is_muldiv) begin
`ifdef CU_MULDIV_EN
                    w_ctrl.loin = 1'b1;
`endif
                end else begin
                    w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                end
            end
            S_T6: begin
                if (w_is_ld) begin
                    w_ctrl.rd = 1'b1; w_ctrl.mdr_sel = 2'b01;
                    w_ctrl.mdrin = (w_next_cnt == 3'd0);
                end else if (w_is_st) begin
                    w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdrin = 1'b1;
                end else begin
`ifdef CU_MULDIV_EN
                    w_ctrl.zhighout = 1'b1; w_ctrl.hiin = 1'b1;
`endif
                end
            end
            S_T7: begin
                if (w_is_st) begin
                    w_ctrl.wr = 1'b1;
                end else begin
                    w_ctrl.mdrout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                end
            end
            default: w_ctrl = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_ctrl  <= w_ctrl;
        end
    end

    assign PCout    = r_ctrl.pcout;
    assign Zlowout  = r_ctrl.zlowout;
    assign Zhighout = r_ctrl.zhighout;
    assign MDRout   = r_ctrl.mdrout;
    assign Cout     = r_ctrl.cout;
    assign Rout     = r_ctrl.rout;
    assign BAout    = r_ctrl.baout;
    assign PCin     = r_ctrl.pcin;
    assign IRin     = r_ctrl.irin;
    assign MARin    = r_ctrl.marin;
    assign MDRin    = r_ctrl.mdrin;
    assign Yin      = r_ctrl.yin;
    assign Zin      = r_ctrl.zin;
    assign Rin      = r_ctrl.rin;
    assign HIin     = r_ctrl.hiin;
    assign LOin     = r_ctrl.loin;
    assign GRA      = r_ctrl.gra;
    assign GRB      = r_ctrl.grb;
    assign GRC      = r_ctrl.grc;
    assign IncPc    = r_ctrl.incpc;
    assign read     = r_ctrl.rd;
    assign write    = r_ctrl.wr;
    assign mdr_read = r_ctrl.mdr_sel;
    assign control  = r_ctrl.alu;
    assign run      = r_ctrl.run;
    assign state_D  = r_state;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: two instances (MEM_WAIT=1 and 3) share clk/reset/IRval.
// The driver pushes per-cycle expected output vectors; the negedge monitor pops and compares.
module tb_control_sequencer;
  localparam logic [4:0] S_IDLE = 5'd0, S_T0 = 5'd1, S_T1 = 5'd2, S_T2 = 5'd3, S_T3 = 5'd4;
  localparam logic [4:0] S_T4 = 5'd5, S_T5 = 5'd6, S_T6 = 5'd7, S_T7 = 5'd8, S_HALT = 5'd31;

  localparam logic [21:0] M_READ   = 22'd1 << 21, M_WRITE = 22'd1 << 20, M_INCPC = 22'd1 << 19;
  localparam logic [21:0] M_GRA    = 22'd1 << 18, M_GRB   = 22'd1 << 17, M_GRC   = 22'd1 << 16;
  localparam logic [21:0] M_PCOUT  = 22'd1 << 15, M_ZLO   = 22'd1 << 14, M_ZHI   = 22'd1 << 13;
  localparam logic [21:0] M_MDROUT = 22'd1 << 12, M_COUT  = 22'd1 << 11, M_ROUT  = 22'd1 << 10;
  localparam logic [21:0] M_BAOUT  = 22'd1 << 9,  M_PCIN  = 22'd1 << 8,  M_IRIN  = 22'd1 << 7;
  localparam logic [21:0] M_MARIN  = 22'd1 << 6,  M_MDRIN = 22'd1 << 5,  M_YIN   = 22'd1 << 4;
  localparam logic [21:0] M_ZIN    = 22'd1 << 3,  M_RIN   = 22'd1 << 2,  M_HIIN  = 22'd1 << 1;
  localparam logic [21:0] M_LOIN   = 22'd1 << 0,  M_NONE  = 22'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IRval = 32'd0;
  int          sel = 0;

  logic [1:0] PCout, Zlowout, Zhighout, MDRout, Cout, Rout, BAout;
  logic [1:0] PCin, IRin, MARin, MDRin, Yin, Zin, Rin, HIin, LOin;
  logic [1:0] GRA, GRB, GRC, IncPc, read, write, run;
  logic [1:0] mdr_o [2];
  logic [3:0] ctl_o [2];
  logic [4:0] st_o [2];

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];
  string       name_q[$];
  logic [33:0] mon_obs;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  control_sequencer #(.MEM_WAIT(1)) dut_w1 (
    .clk(clk), .reset(reset), .IRval(IRval),
    .PCout(PCout[0]), .Zlowout(Zlowout[0]), .Zhighout(Zhighout[0]), .MDRout(MDRout[0]),
    .Cout(Cout[0]), .Rout(Rout[0]), .BAout(BAout[0]),
    .PCin(PCin[0]), .IRin(IRin[0]), .MARin(MARin[0]), .MDRin(MDRin[0]), .Yin(Yin[0]),
    .Zin(Zin[0]), .Rin(Rin[0]), .HIin(HIin[0]), .LOin(LOin[0]),
    .GRA(GRA[0]), .GRB(GRB[0]), .GRC(GRC[0]), .IncPc(IncPc[0]),
    .read(read[0]), .write(write[0]), .mdr_read(mdr_o[0]), .control(ctl_o[0]),
    .run(run[0]), .state_D(st_o[0])
  );

  control_sequencer #(.MEM_WAIT(3)) dut_w3 (
    .clk(clk), .reset(reset), .IRval(IRval),
    .PCout(PCout[1]), .Zlowout(Zlowout[1]), .Zhighout(Zhighout[1]), .MDRout(MDRout[1]),
    .Cout(Cout[1]), .Rout(Rout[1]), .BAout(BAout[1]),
    .PCin(PCin[1]), .IRin(IRin[1]), .MARin(MARin[1]), .MDRin(MDRin[1]), .Yin(Yin[1]),
    .Zin(Zin[1]), .Rin(Rin[1]), .HIin(HIin[1]), .LOin(LOin[1]),
    .GRA(GRA[1]), .GRB(GRB[1]), .GRC(GRC[1]), .IncPc(IncPc[1]),
    .read(read[1]), .write(write[1]), .mdr_read(mdr_o[1]), .control(ctl_o[1]),
    .run(run[1]), .state_D(st_o[1])
  );

  function automatic logic [33:0] get_obs(int k);
    return {st_o[k], run[k], ctl_o[k], mdr_o[k],
            read[k], write[k], IncPc[k], GRA[k], GRB[k], GRC[k],
            PCout[k], Zlowout[k], Zhighout[k], MDRout[k], Cout[k], Rout[k], BAout[k],
            PCin[k], IRin[k], MARin[k], MDRin[k], Yin[k], Zin[k], Rin[k], HIin[k], LOin[k]};
  endfunction

  function automatic logic [33:0] v(logic [4:0] st, logic r, logic [3:0] c, logic [1:0] m,
                                    logic [21:0] s);
    return {st, r, c, m, s};
  endfunction

  function void check(string n, logic [33:0] got, logic [33:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (state,run,ctl,mdr,strobes)", n, got, exp);
    end
  endfunction

  function void check_flag(string n, logic ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL %s got=%b exp=1", n, ok);
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_obs = get_obs(sel);
      check(name_q.pop_front(), mon_obs, exp_q.pop_front());
      check_flag("bus_onehot0", $onehot0(mon_obs[15:10]));
      check_flag("rd_wr_exclusive", !(mon_obs[21] && mon_obs[20]));
    end
  end

  // driver tasks
  task automatic push(string n, logic [33:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic start(int k, logic [31:0] ir);
    @(posedge clk);
    #1;
    reset = 1'b1;
    IRval = ir;
    sel = k;
    #1;
    check("reset_state", get_obs(k), 34'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push("idle", v(S_IDLE, 1'b0, 4'd0, 2'b00, M_NONE));
  endtask

  task automatic push_t0(string n);
    push(n, v(S_T0, 1'b1, 4'd3, 2'b00, M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
  endtask

  task automatic fetch(int mw);
    push_t0("t0");
    for (int i = 0; i < mw; i++)
      push("t1", v(S_T1, 1'b1, 4'd0, 2'b01,
                   M_ZLO | M_PCIN | M_READ | ((i == mw - 1) ? M_MDRIN : M_NONE)));
    push("t2", v(S_T2, 1'b1, 4'd0, 2'b00, M_MDROUT | M_IRIN));
  endtask

  task automatic addr_steps(string n);
    push({n, "_t3"}, v(S_T3, 1'b1, 4'd0, 2'b00, M_GRB | M_BAOUT | M_YIN));
    push({n, "_t4"}, v(S_T4, 1'b1, 4'd3, 2'b00, M_COUT | M_ZIN));
    push({n, "_t5"}, v(S_T5, 1'b1, 4'd0, 2'b00, M_ZLO | M_MARIN));
  endtask

  task automatic alu3(string n, logic [3:0] op);
    push({n, "_t3"}, v(S_T3, 1'b1, 4'd0, 2'b00, M_GRB | M_ROUT | M_YIN));
    push({n, "_t4"}, v(S_T4, 1'b1, op, 2'b00, M_GRC | M_ROUT | M_ZIN));
    push({n, "_t5"}, v(S_T5, 1'b1, 4'd0, 2'b00, M_ZLO | M_GRA | M_RIN));
    push_t0({n, "_back_t0"});
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    // add, MEM_WAIT=1
    start(0, 32'h1800_0000);
    fetch(1);
    alu3("add", 4'd3);
    drain();

    // sub, MEM_WAIT=3: read held three T1 cycles, MDRin on the last
    start(1, 32'h2000_0000);
    fetch(3);
    alu3("sub", 4'd4);
    drain();

    // st, MEM_WAIT=1 and 3
    for (int k = 0; k < 2; k++) begin
      start(k, 32'h1000_0000);
      fetch(k == 0 ? 1 : 3);
      addr_steps("st");
      push("st_t6", v(S_T6, 1'b1, 4'd0, 2'b00, M_GRA | M_ROUT | M_MDRIN));
      for (int i = 0; i < (k == 0 ? 1 : 3); i++)
        push("st_t7", v(S_T7, 1'b1, 4'd0, 2'b00, M_WRITE));
      push_t0("st_back_t0");
      drain();
    end

    // ld, MEM_WAIT=3
    start(1, 32'h0000_0000);
    fetch(3);
    addr_steps("ld");
    for (int i = 0; i < 3; i++)
      push("ld_t6", v(S_T6, 1'b1, 4'd0, 2'b01, M_READ | ((i == 2) ? M_MDRIN : M_NONE)));
    push("ld_t7", v(S_T7, 1'b1, 4'd0, 2'b00, M_MDROUT | M_GRA | M_RIN));
    push_t0("ld_back_t0");
    drain();

    // andi
    start(0, 32'h6800_0000);
    fetch(1);
    push("andi_t3", v(S_T3, 1'b1, 4'd0, 2'b00, M_GRB | M_ROUT | M_YIN));
    push("andi_t4", v(S_T4, 1'b1, 4'd5, 2'b00, M_COUT | M_ZIN));
    push("andi_t5", v(S_T5, 1'b1, 4'd0, 2'b00, M_ZLO | M_GRA | M_RIN));
    push_t0("andi_back_t0");
    drain();

    // jr
    start(0, 32'hA000_0000);
    fetch(1);
    push("jr_t3", v(S_T3, 1'b1, 4'd0, 2'b00, M_GRA | M_ROUT | M_PCIN));
    push_t0("jr_back_t0");
    drain();

    // mul
    start(0, 32'h7800_0000);
    fetch(1);
`ifdef CU_MULDIV_EN
    push("mul_t3", v(S_T3, 1'b1, 4'd0, 2'b00, M_GRA | M_ROUT | M_YIN));
    push("mul_t4", v(S_T4, 1'b1, 4'd15, 2'b00, M_GRB | M_ROUT | M_ZIN));
    push("mul_t5", v(S_T5, 1'b1, 4'd0, 2'b00, M_ZLO | M_LOIN));
    push("mul_t6", v(S_T6, 1'b1, 4'd0, 2'b00, M_ZHI | M_HIIN));
`else
    push("mul_as_nop_t3", v(S_T3, 1'b1, 4'd0, 2'b00, M_NONE));
`endif
    push_t0("mul_back_t0");
    drain();

    // halt, then asynchronous reset between edges
    start(0, 32'hC800_0000);
    fetch(1);
    push("halt_t3", v(S_T3, 1'b1, 4'd0, 2'b00, M_NONE));
    for (int i = 0; i < 20; i++)
      push("halted", v(S_HALT, 1'b0, 4'd0, 2'b00, M_NONE));
    drain();
    #2;
    reset = 1'b1;
    #1;
    check("halt_async_reset", get_obs(0), 34'd0);

    // ld aborted by reset in T7, then restart
    start(0, 32'h0000_0000);
    fetch(1);
    addr_steps("ldab");
    push("ldab_t6", v(S_T6, 1'b1, 4'd0, 2'b01, M_READ | M_MDRIN));
    push("ldab_t7", v(S_T7, 1'b1, 4'd0, 2'b00, M_MDROUT | M_GRA | M_RIN));
    drain();
    #2;
    reset = 1'b1;
    #1;
    check("ld_t7_abort", get_obs(0), 34'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push("restart_idle", v(S_IDLE, 1'b0, 4'd0, 2'b00, M_NONE));
    push_t0("restart_t0");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
